// File: rtl/reg_bank_reader.sv
// Burst reader: streams NUM_REG-wrapped consecutive bank registers per (start, length) request.
// Latency: first beat valid 1 cycle after request acceptance, then 1 beat/cycle.
// Backpressure: single output slot; nothing advances while o_rsp_valid && !i_rsp_ready.
module reg_bank_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REG = 6,
  localparam int SELECT_WIDTH = $clog2(NUM_REG),
  localparam int LEN_WIDTH = $clog2(NUM_REG + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   i_bank_data [NUM_REG],
  input  logic                    i_write_enable,
  input  logic [SELECT_WIDTH-1:0] i_write_select,
  input  logic [DATA_WIDTH-1:0]   i_write_data,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [SELECT_WIDTH-1:0] i_req_addr,
  input  logic [LEN_WIDTH-1:0]    i_req_len,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [SELECT_WIDTH-1:0] o_rsp_addr,
  output logic                    o_rsp_last,
  output logic                    o_rsp_err
);

  typedef enum logic {IDLE, BURST} state_t;

  // Address compare is one bit wider so a power-of-two NUM_REG still detects out-of-range.
  localparam logic [SELECT_WIDTH:0]   NUM_REG_A = (SELECT_WIDTH + 1)'(NUM_REG);
  localparam logic [LEN_WIDTH-1:0]    MAX_LEN   = LEN_WIDTH'(NUM_REG);
  localparam logic [SELECT_WIDTH-1:0] LAST_IDX  = SELECT_WIDTH'(NUM_REG - 1);

  state_t                  state_q, state_d;
  logic [SELECT_WIDTH-1:0] cur_q;
  logic [LEN_WIDTH-1:0]    remain_q;
  logic                    bad_q;

  logic                    slot_free;
  logic                    req_fire;
  logic                    req_bad;
  logic                    load_beat;
  logic                    beat_last;
  logic [DATA_WIDTH-1:0]   bank_rd;
  logic [DATA_WIDTH-1:0]   beat_data;

  assign slot_free = !o_rsp_valid || i_rsp_ready;
  assign req_fire  = i_req_valid && o_req_ready;
  assign req_bad   = (i_req_len == '0) || (i_req_len > MAX_LEN) ||
                     ({1'b0, i_req_addr} >= NUM_REG_A);
  assign beat_last = bad_q || (remain_q == LEN_WIDTH'(1));

  // Read mux over the bank; explicit compare keeps an out-of-range index harmless.
  always_comb begin
    bank_rd = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (cur_q == SELECT_WIDTH'(i)) bank_rd = i_bank_data[i];
    end
  end

  // A write landing on the register being loaded this cycle wins over the stale bus value.
  always_comb begin
    beat_data = bank_rd;
    if (i_write_enable && (i_write_select == cur_q)) beat_data = i_write_data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, request ready and beat-load strobe.
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    load_beat   = 1'b0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = BURST;
      end
      BURST: begin
        if (slot_free) begin
          load_beat = 1'b1;
          if (beat_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst cursor: latched on acceptance, advanced with wrap on every beat load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q    <= '0;
      remain_q <= '0;
      bad_q    <= 1'b0;
    end else if (req_fire) begin
      cur_q    <= i_req_addr;
      remain_q <= i_req_len;
      bad_q    <= req_bad;
    end else if (load_beat) begin
      cur_q    <= (cur_q == LAST_IDX) ? '0 : cur_q + SELECT_WIDTH'(1);
      remain_q <= remain_q - LEN_WIDTH'(1);
    end
  end

  // Output slot: load a beat when free, otherwise drain on handshake, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_addr  <= '0;
      o_rsp_last  <= 1'b0;
      o_rsp_err   <= 1'b0;
    end else if (load_beat) begin
      o_rsp_valid <= 1'b1;
      o_rsp_data  <= bad_q ? '0 : beat_data;
      o_rsp_addr  <= cur_q;
      o_rsp_last  <= beat_last;
      o_rsp_err   <= bad_q;
    end else if (o_rsp_valid && i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Bench for reg_bank_reader: request table plus hand sequences, beats checked against a queue.
// Latency: DUT first beat expected 1 cycle after accept.
// Backpressure: ready driven always-high, random, or manually per test.
module tb_reg_bank_reader;

  logic       clk;
  logic       rst;
  logic [7:0] bank [6];
  logic       i_write_enable;
  logic [2:0] i_write_select;
  logic [7:0] i_write_data;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [2:0] i_req_addr;
  logic [2:0] i_req_len;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_data;
  logic [2:0] o_rsp_addr;
  logic       o_rsp_last;
  logic       o_rsp_err;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       last;
    logic       err;
  } beat_t;

  typedef struct {
    logic [2:0] addr;
    logic [2:0] len;
    int         rmode;
    int         exp_beats;
  } vec_t;

  beat_t sb [$];
  int    n_vec = 0;
  int    n_err = 0;
  int    beat_cnt = 0;
  int    rdy_mode = 0;

  reg_bank_reader #(.DATA_WIDTH(8), .NUM_REG(6)) dut (
    .clk(clk), .rst(rst), .i_bank_data(bank),
    .i_write_enable(i_write_enable), .i_write_select(i_write_select), .i_write_data(i_write_data),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_addr(o_rsp_addr), .o_rsp_last(o_rsp_last), .o_rsp_err(o_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for reg_bank: preloaded r[i]=0x10+i, written on the clock edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) bank[i] <= 8'h10 + 8'(i);
    end else if (i_write_enable && i_write_select < 3'd6) begin
      bank[i_write_select] <= i_write_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive a request, optionally queue its modelled beats, return one step after the accept edge.
  task automatic do_req(input logic [2:0] addr, input logic [2:0] len, input bit push);
    int t;
    bit bad;
    beat_t b;
    bad = (len == 3'd0) || (len > 3'd6) || (addr >= 3'd6);
    if (push) begin
      if (bad) begin
        b.addr = addr; b.data = 8'h00; b.last = 1'b1; b.err = 1'b1;
        sb.push_back(b);
      end else begin
        for (int k = 0; k < int'(len); k++) begin
          b.addr = 3'((int'(addr) + k) % 6);
          b.data = 8'h10 + 8'(b.addr);
          b.last = (k == int'(len) - 1);
          b.err  = 1'b0;
          sb.push_back(b);
        end
      end
    end
    i_req_addr  = addr;
    i_req_len   = len;
    i_req_valid = 1'b1;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (o_req_ready) break;
      t++;
    end
    chk("req_accept_timeout", 32'(t < 100), 32'd1);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((sb.size() != 0 || o_rsp_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(nm, 32'(t < 200), 32'd1);
    if (t >= 200) sb.delete();
  endtask

  initial begin
    vec_t vt [10];
    int   base;
    beat_t b;

    vt[0] = '{addr: 3'd1, len: 3'd3, rmode: 0, exp_beats: 3};
    vt[1] = '{addr: 3'd4, len: 3'd4, rmode: 0, exp_beats: 4};
    vt[2] = '{addr: 3'd0, len: 3'd6, rmode: 0, exp_beats: 6};
    vt[3] = '{addr: 3'd3, len: 3'd6, rmode: 1, exp_beats: 6};
    vt[4] = '{addr: 3'd5, len: 3'd1, rmode: 0, exp_beats: 1};
    vt[5] = '{addr: 3'd2, len: 3'd5, rmode: 1, exp_beats: 5};
    vt[6] = '{addr: 3'd0, len: 3'd0, rmode: 0, exp_beats: 1};
    vt[7] = '{addr: 3'd7, len: 3'd1, rmode: 0, exp_beats: 1};
    vt[8] = '{addr: 3'd2, len: 3'd7, rmode: 1, exp_beats: 1};
    vt[9] = '{addr: 3'd6, len: 3'd2, rmode: 0, exp_beats: 1};

    rst = 1'b0;
    i_write_enable = 1'b0; i_write_select = '0; i_write_data = '0;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_len = '0; i_rsp_ready = 1'b1;

    fork
      // Watchdog.
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
      // Ready driver for the always-high and random modes.
      forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) i_rsp_ready = 1'b1;
        else if (rdy_mode == 1) i_rsp_ready = 1'($urandom_range(0, 1));
      end
      // Monitor: scoreboard pops on handshake, and held beats must not change.
      begin
        bit    hold_vld;
        beat_t held;
        beat_t exp;
        hold_vld = 1'b0;
        forever begin
          @(negedge clk);
          if (!rst) begin
            hold_vld = 1'b0;
          end else begin
            if (hold_vld && o_rsp_valid) begin
              chk("hold_addr", 32'(o_rsp_addr), 32'(held.addr));
              chk("hold_data", 32'(o_rsp_data), 32'(held.data));
              chk("hold_last", 32'(o_rsp_last), 32'(held.last));
              chk("hold_err",  32'(o_rsp_err),  32'(held.err));
            end
            hold_vld  = o_rsp_valid && !i_rsp_ready;
            held.addr = o_rsp_addr; held.data = o_rsp_data;
            held.last = o_rsp_last; held.err  = o_rsp_err;
            if (o_rsp_valid && i_rsp_ready) begin
              beat_cnt++;
              if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_beat: got addr %0h data %0h, none expected", o_rsp_addr, o_rsp_data);
              end else begin
                exp = sb.pop_front();
                chk("beat_addr", 32'(o_rsp_addr), 32'(exp.addr));
                chk("beat_data", 32'(o_rsp_data), 32'(exp.data));
                chk("beat_last", 32'(o_rsp_last), 32'(exp.last));
                chk("beat_err",  32'(o_rsp_err),  32'(exp.err));
              end
            end
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_last",  32'(o_rsp_last),  32'd0);
    chk("rst_err",   32'(o_rsp_err),   32'd0);
    chk("rst_data",  32'(o_rsp_data),  32'd0);
    chk("rst_addr",  32'(o_rsp_addr),  32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;

    // Latency and back-to-back beats.
    rdy_mode = 0;
    @(posedge clk); #1;
    do_req(3'd1, 3'd3, 1'b1);
    chk("t1_valid_e0", 32'(o_rsp_valid), 32'd0);
    chk("t1_ready_e0", 32'(o_req_ready), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk("t1_valid_run", 32'(o_rsp_valid), 32'd1);
    end
    chk("t1_ready_after_last", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    chk("t1_valid_end", 32'(o_rsp_valid), 32'd0);
    drain("t1_drain");

    // Backpressure: first beat held for three cycles.
    rdy_mode = 2;
    i_rsp_ready = 1'b0;
    base = beat_cnt;
    do_req(3'd0, 3'd3, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("t3_held_valid", 32'(o_rsp_valid), 32'd1);
      chk("t3_held_addr",  32'(o_rsp_addr),  32'd0);
      chk("t3_held_data",  32'(o_rsp_data),  32'h10);
    end
    i_rsp_ready = 1'b1;
    drain("t3_drain");
    chk("t3_nbeats", 32'(beat_cnt - base), 32'd3);

    // Write forwarding on the loading register, no effect on an already loaded beat.
    i_rsp_ready = 1'b0;
    b.addr = 3'd2; b.data = 8'h12; b.last = 1'b0; b.err = 1'b0; sb.push_back(b);
    b.addr = 3'd3; b.data = 8'hAA; b.last = 1'b1; b.err = 1'b0; sb.push_back(b);
    do_req(3'd2, 3'd2, 1'b0);
    @(posedge clk); #1;
    chk("t4_beat0_data", 32'(o_rsp_data), 32'h12);
    i_write_enable = 1'b1; i_write_select = 3'd2; i_write_data = 8'h55;
    @(posedge clk); #1;
    chk("t4_beat0_kept", 32'(o_rsp_data), 32'h12);
    i_write_select = 3'd3; i_write_data = 8'hAA;
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_write_enable = 1'b0;
    chk("t4_fwd_data", 32'(o_rsp_data), 32'hAA);
    chk("t4_fwd_last", 32'(o_rsp_last), 32'd1);
    drain("t4_drain");

    // Reset in the middle of a full burst.
    rdy_mode = 0;
    do_req(3'd0, 3'd6, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_valid_in_rst", 32'(o_rsp_valid), 32'd0);
    chk("t6_last_in_rst",  32'(o_rsp_last),  32'd0);
    chk("t6_data_in_rst",  32'(o_rsp_data),  32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("t6_ready_after", 32'(o_req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("t6_no_stale", 32'(o_rsp_valid), 32'd0);
    end

    // Request table: wrap, full sweeps, random backpressure, illegal requests.
    for (int v = 0; v < 10; v++) begin
      rdy_mode = vt[v].rmode;
      base = beat_cnt;
      do_req(vt[v].addr, vt[v].len, 1'b1);
      drain("tbl_drain");
      chk("tbl_nbeats", 32'(beat_cnt - base), 32'(vt[v].exp_beats));
      chk("tbl_ready_idle", 32'(o_req_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
